// File: rtl/io_in_seq.sv
// Input-port sequencer: strobes the low/high port latches, waits for them to settle,
// and hands a 16-bit word (or a zero-extended byte) to the CPU with a valid/ack handshake.
// Optional transfer counter output is enabled by defining IO_IN_XFER_CNT_EN.
module io_in_seq #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_req,
  input  logic        in_byte,
  input  logic [7:0]  data_inL,
  input  logic [7:0]  data_inH,
  input  logic        data_ack,
  output logic        wr_L,
  output logic        wr_H,
  output logic [15:0] data_out,
  output logic        data_valid,
  output logic        busy
`ifdef IO_IN_XFER_CNT_EN
  ,
  output logic [7:0]  xfer_cnt
`endif
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] STROBE_L = 3'd1;
  localparam logic [2:0] WAIT_L   = 3'd2;
  localparam logic [2:0] STROBE_H = 3'd3;
  localparam logic [2:0] WAIT_H   = 3'd4;
  localparam logic [2:0] VALID    = 3'd5;

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

  logic [2:0] state;
  logic [3:0] settle_cnt;
  logic       byte_mode;

  // Every output is a flop; strobes and valid are set on the edge that enters their state,
  // so they line up with the state they belong to without any combinational decode.
  // NOTE: all sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      settle_cnt <= 4'd0;
      byte_mode  <= 1'b0;
      wr_L       <= 1'b0;
      wr_H       <= 1'b0;
      data_out   <= 16'h0000;
      data_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      wr_L <= 1'b0;
      wr_H <= 1'b0;
      case (state)
        IDLE: begin
          if (in_req) begin
            byte_mode <= in_byte;
            wr_L      <= 1'b1;
            busy      <= 1'b1;
            state     <= STROBE_L;
          end
        end
        STROBE_L: begin
          settle_cnt <= SETTLE_INIT;
          state      <= WAIT_L;
        end
        WAIT_L: begin
          settle_cnt <= settle_cnt - 4'd1;
          if (settle_cnt == 4'd1) begin
            data_out[7:0] <= data_inL;
            if (byte_mode) begin
              data_out[15:8] <= 8'h00;
              data_valid     <= 1'b1;
              state          <= VALID;
            end else begin
              wr_H  <= 1'b1;
              state <= STROBE_H;
            end
          end
        end
        STROBE_H: begin
          settle_cnt <= SETTLE_INIT;
          state      <= WAIT_H;
        end
        WAIT_H: begin
          settle_cnt <= settle_cnt - 4'd1;
          if (settle_cnt == 4'd1) begin
            data_out[15:8] <= data_inH;
            data_valid     <= 1'b1;
            state          <= VALID;
          end
        end
        VALID: begin
          // A request arriving with the ack is dropped; only IDLE accepts new work.
          if (data_ack) begin
            data_valid <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          data_valid <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

`ifdef IO_IN_XFER_CNT_EN
  // Counts completed handshakes; wraps naturally at 8 bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      xfer_cnt <= 8'd0;
    end else if (state == VALID && data_ack) begin
      xfer_cnt <= xfer_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_io_in_seq.sv
// Randomized self-checking bench for io_in_seq: a latch model feeds data_inL/H, and a
// cycle-level reference built from the latency formulas predicts strobes, valid and data.
module tb_io_in_seq;

  localparam int S = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_req = 1'b0;
  logic        in_byte = 1'b0;
  logic [7:0]  data_inL = 8'h00;
  logic [7:0]  data_inH = 8'h00;
  logic        data_ack = 1'b0;
  logic        wr_L, wr_H;
  logic [15:0] data_out;
  logic        data_valid, busy;
`ifdef IO_IN_XFER_CNT_EN
  logic [7:0]  xfer_cnt;
  logic [7:0]  exp_cnt = 8'd0;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  io0 = 8'h00, io1 = 8'h00;
  logic [15:0] prev_out = 16'h0000;

  io_in_seq #(.SETTLE_CYCLES(S)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_req     (in_req),
    .in_byte    (in_byte),
    .data_inL   (data_inL),
    .data_inH   (data_inH),
    .data_ack   (data_ack),
    .wr_L       (wr_L),
    .wr_H       (wr_H),
    .data_out   (data_out),
    .data_valid (data_valid),
    .busy       (busy)
`ifdef IO_IN_XFER_CNT_EN
    ,
    .xfer_cnt   (xfer_cnt)
`endif
  );

  always #5 clk = ~clk;

  // External port latches: load the pin value on the edge that ends a strobe cycle.
  always @(posedge clk) begin
    if (wr_L) data_inL <= io0;
    if (wr_H) data_inH <= io1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, want);
    end
  endtask

  // Runs one transfer starting at a negedge in IDLE; returns at a negedge back in IDLE.
  task automatic do_xfer(input bit byt, input logic [7:0] lo, input logic [7:0] hi,
                         input int hold, input bit poke_busy, input bit req_with_ack);
    int          v;
    logic [15:0] exp_word;
    v        = byt ? 2 + S : 3 + 2 * S;
    exp_word = byt ? {8'h00, lo} : {hi, lo};
    io0      = lo;
    io1      = hi;
    in_req   = 1'b1;
    in_byte  = byt;
    data_ack = 1'b0;
    for (int k = 1; k <= v; k++) begin
      @(negedge clk);
      check("wr_L", wr_L, (k == 1));
      check("wr_H", wr_H, (!byt && k == 2 + S));
      check("valid", data_valid, (k == v));
      check("busy", busy, 1);
      if (k <= S + 1) check("hold_prev", data_out, prev_out);
      if (k == v) check("data_out", data_out, exp_word);
      in_req   = (poke_busy && k == 2);
      in_byte  = 1'($urandom);
      data_ack = (k < v) ? 1'($urandom) : 1'b0;
    end
    for (int h = 1; h <= hold; h++) begin
      @(negedge clk);
      check("valid_hold", data_valid, 1);
      check("data_hold", data_out, exp_word);
      check("no_strobe", {wr_L, wr_H}, 2'b00);
    end
    data_ack = 1'b1;
    in_req   = req_with_ack;
    @(negedge clk);
    data_ack = 1'b0;
    in_req   = 1'b0;
    prev_out = exp_word;
    check("valid_clr", data_valid, 0);
    check("busy_clr", busy, 0);
    check("idle_keep", data_out, exp_word);
`ifdef IO_IN_XFER_CNT_EN
    exp_cnt = exp_cnt + 8'd1;
    check("xfer_cnt", xfer_cnt, exp_cnt);
`endif
    if (req_with_ack) begin
      @(negedge clk);
      check("req_ack_ignored", {busy, wr_L}, 2'b00);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_out", {wr_L, wr_H, data_valid, busy}, 4'b0000);
      check("rst_data", data_out, 16'h0000);
`ifdef IO_IN_XFER_CNT_EN
      check("rst_cnt", xfer_cnt, 8'd0);
`endif
    end

    do_xfer(1'b0, 8'hA5, 8'h3C, 4, 1'b0, 1'b0);
    do_xfer(1'b1, 8'h7E, 8'hFF, 0, 1'b0, 1'b0);
    do_xfer(1'b0, 8'($urandom), 8'($urandom), 1, 1'b1, 1'b1);

    // Asynchronous reset in the wr_H cycle of a word transfer.
    io0    = 8'($urandom);
    io1    = 8'($urandom);
    in_req = 1'b1;
    in_byte = 1'b0;
    for (int k = 1; k <= 2 + S; k++) begin
      @(negedge clk);
      in_req = 1'b0;
    end
    check("pre_rst_wrH", wr_H, 1);
    reset = 1'b0;
    #1;
    check("arst_wrH", wr_H, 0);
    check("arst_data", data_out, 16'h0000);
    check("arst_flags", {wr_L, data_valid, busy}, 3'b000);
    prev_out = 16'h0000;
`ifdef IO_IN_XFER_CNT_EN
    exp_cnt = 8'd0;
    check("arst_cnt", xfer_cnt, 8'd0);
`endif
    @(negedge clk);
    reset = 1'b1;

    for (int t = 0; t < 257; t++) begin
      do_xfer(1'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 2)),
              1'($urandom), 1'($urandom));
    end
`ifdef IO_IN_XFER_CNT_EN
    check("cnt_wrap", xfer_cnt, exp_cnt);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
